// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding,
// counter widths and a constant-foldable ceiling-log2 helper.
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_GAP  = 2'b10
  } state_e;

  // Width of the WAIT-state watchdog counter; TO_CYC must fit in it.
  localparam int TO_CNT_W = 24;

  // Ceiling log2 with a floor of 1 bit, so a 1- or 2-entry index still has a port.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Round-robin picker: returns the first set request at or after ptr, wrapping
// modulo NREQ. Purely combinational so other arbiters can share it.
module uart_tx_scheduler_rr_pick
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   sel,
  output logic            valid
);

  logic [PW:0] idx;

  // Scan ptr, ptr+1, ... and latch onto the first pending requester.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      // ptr < NREQ, so one conditional subtract is enough to wrap.
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!valid && req[idx[PW-1:0]]) begin
        valid = 1'b1;
        sel   = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART Tx engine between NREQ byte producers: round-robin grant,
// one-cycle load pulse, wait for frame-done (with watchdog), then an idle gap
// measured in bit-time pulses before the next frame may start.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int DW      = 8,
  parameter  int GAP_BTU = 1,
  parameter  int TO_CYC  = 2000000,
  localparam int OW      = clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic                 btu,
  input  logic                 tx_done,
  output logic                 tx_load,
  output logic [DW-1:0]        tx_data,
  output logic [NREQ-1:0]      gnt,
  output logic [OW-1:0]        owner,
  output logic                 busy,
  output logic                 timeout
);

  localparam int GW = clog2(GAP_BTU + 2);

  state_e              state_q, state_d;
  logic                tx_load_q, tx_load_d;
  logic [DW-1:0]       tx_data_q, tx_data_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       ptr_q, ptr_d;
  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic                timeout_q, timeout_d;
  logic                busy_q, busy_d;

  logic [OW-1:0]       pick_sel;
  logic                pick_valid;
  logic [DW-1:0]       pick_data;
  logic [OW-1:0]       pick_next;
  logic                to_hit;
  logic                gap_last;

  uart_tx_scheduler_rr_pick #(
    .NREQ (NREQ),
    .PW   (OW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .sel   (pick_sel),
    .valid (pick_valid)
  );

  // Byte mux for the selected requester plus the rotated pointer that follows it.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_sel == OW'(i)) pick_data = req_data[i*DW +: DW];
    end
    pick_next = (pick_sel == OW'(NREQ-1)) ? '0 : pick_sel + OW'(1);
  end

  // The watchdog fires on the edge where the counter already holds TO_CYC-1,
  // i.e. TO_CYC edges after the load; the gap ends on the GAP_BTU-th btu.
  assign to_hit   = (to_cnt_q == TO_CNT_W'(TO_CYC - 1));
  assign gap_last = (gap_cnt_q == GW'(GAP_BTU - 1));

  // State register and all output/datapath flops, with synchronous reset.
  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_load_q <= 1'b0;
      tx_data_q <= '0;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      gap_cnt_q <= '0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_load_q <= tx_load_d;
      tx_data_q <= tx_data_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      gap_cnt_q <= gap_cnt_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic: grant from IDLE, leave WAIT on done or watchdog, leave GAP on last btu.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // tx_done wins over a coincident btu and over the watchdog.
        if (tx_done)     state_d = (GAP_BTU == 0) ? ST_IDLE : ST_GAP;
        else if (to_hit) state_d = ST_IDLE;
      end
      ST_GAP: begin
        if (btu && gap_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and counter updates; load/gnt default low so they pulse for one cycle only.
  always_comb begin
    tx_load_d = 1'b0;
    gnt_d     = '0;
    tx_data_d = tx_data_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    gap_cnt_d = gap_cnt_q;
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          tx_load_d = 1'b1;
          gnt_d     = NREQ'(1) << pick_sel;
          tx_data_d = pick_data;
          owner_d   = pick_sel;
          ptr_d     = pick_next;
          to_cnt_d  = '0;
        end
      end
      ST_WAIT: begin
        if (tx_done) begin
          to_cnt_d  = '0;
          gap_cnt_d = '0;
        end else if (to_hit) begin
          timeout_d = 1'b1;
          to_cnt_d  = '0;
        end else begin
          to_cnt_d  = to_cnt_q + TO_CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (btu) gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: begin
        // Unreachable encoding: park in IDLE with a clean datapath.
        tx_data_d = '0;
        owner_d   = '0;
        ptr_d     = '0;
        gap_cnt_d = '0;
        to_cnt_d  = '0;
      end
    endcase
    busy_d = (state_d == ST_WAIT) || (state_d == ST_GAP);
  end

  assign tx_load = tx_load_q;
  assign tx_data = tx_data_q;
  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares the single UART transmit engine between NREQ byte producers, for example the command echo, status reporter and TSI reply paths.
- Picks one pending requester and captures its byte.
- Issues a one-cycle load to the Tx engine, then waits for the engine's frame-done pulse.
- Enforces a programmable idle gap, counted in bit-time units, before the next frame.
- Sits between the requesters and the Tx engine, on the same clk/btu timebase as the receive path.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, data byte width
GAP_BTU, 1, idle bit-times inserted after each frame (0 = no gap)
TO_CYC, 2000000, clocks allowed in WAIT before timeout; must fit in 24 bits

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
req  in  NREQ  per-requester pending flag; held high until matching gnt bit
req_data  in  NREQ*DW  byte of requester i in bits [i*DW +: DW]
btu  in  1  bit-time-up pulse from the baud generator
tx_done  in  1  one-cycle pulse from the Tx engine at end of stop bit
tx_load  out  1  one-cycle pulse; starts a frame with tx_data
tx_data  out  DW  registered byte, stable from tx_load until the next grant
gnt  out  NREQ  one-hot, one-cycle pulse coincident with tx_load
owner  out  clog2(NREQ)  index of last granted requester
busy  out  1  high in WAIT and GAP
timeout  out  1  sticky error flag; cleared only by rst

Behaviour:
- Reset is synchronous (rst sampled on posedge clk).
- Reset values:
  - state=IDLE, tx_load=0, gnt=0, tx_data=0, owner=0
  - rr pointer ptr=0, gap counter=0, timeout counter=0, timeout=0, busy=0
- All outputs are registered.
- States: IDLE, WAIT, GAP.
- IDLE:
  - If |req is high at edge N, select the first set bit scanning ptr, ptr+1, ... mod NREQ.
  - At edge N: tx_data<=req_data[sel], owner<=sel, gnt<=onehot(sel), tx_load<=1, ptr<=(sel+1) mod NREQ, state<=WAIT.
  - Result: tx_load and gnt are high for exactly one cycle after the edge at which req was sampled (1-cycle latency).
  - Otherwise remain in IDLE.
- WAIT:
  - The timeout counter increments each clk.
  - On tx_done: if GAP_BTU=0 go to IDLE, else clear the gap counter and go to GAP. The timeout counter clears either way.
  - If the counter reaches TO_CYC-1 without tx_done: set timeout=1, go to IDLE, clear the counter.
  - req is ignored in WAIT.
- GAP:
  - The gap counter increments on each btu pulse.
  - On the btu pulse that makes count==GAP_BTU, go to IDLE.
  - A tx_done pulse in GAP or IDLE is ignored.
- busy=1 exactly while state is WAIT or GAP.
- Fairness: a requester that keeps req high is served at most once per NREQ grants whenever others are pending.
- A requester dropping req before its grant loses its turn silently; there is no queueing.
- tx_done and btu coincident in WAIT: tx_done is processed and btu is not counted.
- Illegal state encoding returns to IDLE with outputs 0.
- rst mid-frame: everything returns to reset values on the next edge. The Tx engine shares rst, so no partial frame is resumed.
- ptr wraps from NREQ-1 to 0.

Decomposition:
- Shared package/header: state encodings (IDLE=2'b00, WAIT=2'b01, GAP=2'b10) and a clog2 function.
- One sub-module: rr_pick. Purely combinational; inputs req and ptr; outputs sel index and valid. It is reused later by the Rx buffer drain arbiter.
- The FSM, counters and registers stay in uart_tx_scheduler.

Test Plan:
- rst=1 for 3 clks while req=4'b1111 -> tx_load=0, gnt=0, owner=0, busy=0. After release, the first grant is gnt=4'b0001 one cycle after the first sampled edge.
- req=4'b0100, data2=8'hA5 -> next cycle tx_load=1, gnt=4'b0100, tx_data=8'hA5, owner=2. busy stays 1 until tx_done, then through 1 btu, then 0.
- req=4'b1111 held with tx_done returned after each frame -> grant order 0,1,2,3,0. ptr wraps 3->0.
- GAP_BTU=2: tx_done, then req=4'b0001 asserted before the 2nd btu -> no tx_load until the cycle after the edge following the 2nd btu.
- No tx_done for TO_CYC=16 (test override) -> timeout=1 at cycle 16 after load, state IDLE. The next req is granted normally and timeout stays 1.
- rst asserted 5 cycles into WAIT, then tx_done pulsed after reset -> all outputs 0, tx_done ignored, no spurious gnt.
